// File: rtl/lfsr_rand_arbiter_if.sv
// Requester-side bundle of the shared random source: seeding control, req/gnt handshake and issued value.
interface lfsr_rand_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] seed_in;
    logic             reseed;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rnd_out;
    logic             rnd_valid;
    logic             busy;

    modport master (
        output seed_in,
        output reseed,
        output req,
        input  gnt,
        input  rnd_out,
        input  rnd_valid,
        input  busy
    );

    modport slave (
        input  seed_in,
        input  reseed,
        input  req,
        output gnt,
        output rnd_out,
        output rnd_valid,
        output busy
    );
endinterface

// File: rtl/lfsr_rand_arbiter.sv
// Sequences seed load and warm-up of the shared LFSR, then hands its output to requesters round-robin.
// Define LFSR_RANGE_EN to reject LFSR values above RANGE_MAX before granting.
//
// state | meaning
// INIT  | first cycle after reset release
// SEED  | capture seed_in, pulse lfsr_load
// WARM  | LFSR free-runs for WARMUP cycles, busy high
// READY | arbitrate among pending requests
// GAP   | MIN_GAP idle cycles after a grant
module lfsr_rand_arbiter #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 8,
    parameter int               WARMUP    = 16,
    parameter int               MIN_GAP   = 2,
    parameter logic [WIDTH-1:0] RANGE_MAX = 8'd159
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_rand_arbiter_if.slave   bus,
    input  logic [WIDTH-1:0]     lfsr_q,
    output logic [WIDTH-1:0]     lfsr_seed,
    output logic                 lfsr_load
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = 8;
    localparam int GW = 4;
    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(MIN_GAP - 1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("lfsr_rand_arbiter: NREQ must be 2..8");
        end
        if (WARMUP < 1 || WARMUP > 255) begin : g_bad_warmup
            $error("lfsr_rand_arbiter: WARMUP must be 1..255");
        end
        if (MIN_GAP < 1 || MIN_GAP > 15) begin : g_bad_gap
            $error("lfsr_rand_arbiter: MIN_GAP must be 1..15");
        end
        if (RANGE_MAX < 1) begin : g_bad_range
            $error("lfsr_rand_arbiter: RANGE_MAX must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SEED,
        ST_WARM,
        ST_READY,
        ST_GAP
    } state_t;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [WW-1:0]    warm_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [NREQ-1:0]  gnt_q;
    logic [WIDTH-1:0] rnd_q;
    logic             valid_q;
    logic             busy_q;

    logic             pick_found;
    logic [PW-1:0]    pick_idx;
    logic [PW-1:0]    cand;
    logic [NREQ-1:0]  pick_oh;
    logic [PW-1:0]    ptr_next;
    logic             in_range;

    // Walk from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = PW'((int'(ptr) + off) % NREQ);
            if (bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        pick_oh           = '0;
        pick_oh[pick_idx] = 1'b1;
    end

    assign ptr_next = PW'((int'(pick_idx) + 1) % NREQ);

`ifdef LFSR_RANGE_EN
    assign in_range = (lfsr_q <= RANGE_MAX);
`else
    assign in_range = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_INIT;
            ptr       <= '0;
            warm_cnt  <= '0;
            gap_cnt   <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            rnd_q     <= '0;
            busy_q    <= 1'b1;
            lfsr_load <= 1'b0;
            lfsr_seed <= WIDTH'(1);
        end else begin
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            lfsr_load <= 1'b0;
            case (state)
                ST_INIT: begin
                    state <= ST_SEED;
                end
                ST_SEED: begin
                    // An all-zero seed would lock the LFSR up.
                    lfsr_seed <= (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
                    lfsr_load <= 1'b1;
                    warm_cnt  <= WARM_LAST;
                    state     <= ST_WARM;
                end
                ST_WARM: begin
                    if (bus.reseed) begin
                        warm_cnt <= '0;
                        state    <= ST_SEED;
                    end else if (warm_cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= ST_READY;
                    end else begin
                        warm_cnt <= warm_cnt - 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.reseed) begin
                        busy_q <= 1'b1;
                        state  <= ST_SEED;
                    end else if (pick_found && in_range) begin
                        gnt_q   <= pick_oh;
                        valid_q <= 1'b1;
                        rnd_q   <= lfsr_q;
                        ptr     <= ptr_next;
                        gap_cnt <= GAP_LAST;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (bus.reseed) begin
                        busy_q  <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_SEED;
                    end else if (gap_cnt == '0) begin
                        state <= ST_READY;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rnd_valid = valid_q;
    assign bus.rnd_out   = rnd_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rand_arbiter.sv
// Scoreboard bench for lfsr_rand_arbiter: a timeline model queues expected grants, a monitor checks them.
module tb_lfsr_rand_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int WARMUP  = 16;
    localparam int MIN_GAP = 2;
`ifdef LFSR_RANGE_EN
    localparam logic [7:0] RMAX = 8'd15;
    localparam int         WB   = 700;
`else
    localparam logic [7:0] RMAX = 8'd159;
    localparam int         WB   = 60;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] lfsr_q = 8'h01;
    logic [7:0] lfsr_seed;
    logic       lfsr_load;

    lfsr_rand_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    lfsr_rand_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .WARMUP(WARMUP), .MIN_GAP(MIN_GAP), .RANGE_MAX(RMAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .lfsr_q(lfsr_q), .lfsr_seed(lfsr_seed), .lfsr_load(lfsr_load)
    );

    always #5 clk = ~clk;

    // Maximal-length 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
    always @(posedge clk)
        lfsr_q <= lfsr_load ? lfsr_seed : {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    typedef struct {
        int         e;
        int         idx;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         edge_cnt = 0;
    int         seed_edge = 2;
    int         arb_edge = 2 + WARMUP + 1;
    int         ptr = 0;
    logic [7:0] exp_seed = 8'h01;
    logic [7:0] last_val = 8'h00;
    int         gcount = 0;
    int         got_idx[$];
    logic [7:0] got_val[$];
    logic [3:0] hold = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req_v, $time);
        end
    endtask

    function automatic bit in_rng(input logic [7:0] v);
`ifdef LFSR_RANGE_EN
        return v <= RMAX;
`else
        return 1'b1;
`endif
    endfunction

    // Reference timeline: edges are counted from reset release; the edge that leaves SEED is seed_edge,
    // WARMUP warm edges follow, and arbitration may happen from seed_edge+WARMUP+1 on.
    always @(posedge clk or negedge rst) begin : model
        int pick;
        if (!rst) begin
            edge_cnt  = 0;
            seed_edge = 2;
            arb_edge  = 2 + WARMUP + 1;
            ptr       = 0;
            exp_seed  = 8'h01;
            exp_q.delete();
        end else begin
            edge_cnt++;
            if (edge_cnt == seed_edge)
                exp_seed = (bus.seed_in == 8'h00) ? 8'h01 : bus.seed_in;
            if (bus.reseed && edge_cnt > seed_edge) begin
                seed_edge = edge_cnt + 1;
                arb_edge  = seed_edge + WARMUP + 1;
            end else if (edge_cnt >= arb_edge && bus.req != 4'h0 && in_rng(lfsr_q)) begin
                pick = -1;
                for (int k = 0; k < NREQ; k++)
                    if (pick < 0 && bus.req[2'((ptr + k) % NREQ)]) pick = (ptr + k) % NREQ;
                exp_q.push_back('{edge_cnt, pick, lfsr_q});
                ptr      = (pick + 1) % NREQ;
                arb_edge = edge_cnt + MIN_GAP + 1;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t       x;
        logic [3:0] eg;
        if (!rst) begin
            chk("rst_gnt", bus.gnt, 4'h0);
            chk("rst_valid", bus.rnd_valid, 1'b0);
            chk("rst_rnd_out", bus.rnd_out, 8'h00);
            chk("rst_busy", bus.busy, 1'b1);
            chk("rst_lfsr_load", lfsr_load, 1'b0);
            chk("rst_lfsr_seed", lfsr_seed, 8'h01);
            last_val = 8'h00;
        end else begin
            while (exp_q.size() > 0 && exp_q[0].e < edge_cnt) begin
                checks++;
                failures++;
                $display("FAIL missing_grant actual=none required=idx%0d at edge %0d", exp_q[0].idx, exp_q[0].e);
                void'(exp_q.pop_front());
            end
            if (bus.rnd_valid || bus.gnt != 4'h0) begin
                if (exp_q.size() > 0 && exp_q[0].e == edge_cnt) begin
                    x = exp_q.pop_front();
                    eg = 4'h0;
                    eg[2'(x.idx)] = 1'b1;
                    chk("grant_gnt", bus.gnt, eg);
                    chk("grant_valid", bus.rnd_valid, 1'b1);
                    chk("grant_rnd_out", bus.rnd_out, x.val);
`ifdef LFSR_RANGE_EN
                    chk("grant_in_range", bus.rnd_out <= RMAX, 1'b1);
`endif
                    last_val = x.val;
                    got_idx.push_back(x.idx);
                    got_val.push_back(x.val);
                    gcount++;
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual gnt=%b valid=%b required=no grant edge %0d",
                             bus.gnt, bus.rnd_valid, edge_cnt);
                end
            end else begin
                chk("rnd_out_hold", bus.rnd_out, last_val);
            end
            chk("busy", bus.busy, edge_cnt < seed_edge + WARMUP);
            chk("lfsr_load", lfsr_load, edge_cnt == seed_edge);
            chk("lfsr_seed", lfsr_seed, exp_seed);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        bus.reseed = 1'b0;
        bus.req    = bus.req & ~(bus.gnt & ~hold);
    endtask

    task automatic wait_grants(input int n, input string name);
        int target = gcount + n;
        int t = 0;
        while (gcount < target && t < WB * n) begin
            step();
            t++;
        end
        chk(name, gcount >= target, 1'b1);
    endtask

    task automatic do_reset(input logic [7:0] seed);
        @(negedge clk);
        #2 rst = 1'b0;
        bus.req    = 4'h0;
        bus.reseed = 1'b0;
        hold       = 4'h0;
        repeat (3) @(negedge clk);
        bus.seed_in = seed;
        #2 rst = 1'b1;
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit found;
        bus.req     = 4'h0;
        bus.reseed  = 1'b0;
        bus.seed_in = 8'h03;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (22) step();

        do_reset(8'h00);
        repeat (22) step();

        // All requesters held: strict rotation from pointer 0.
        got_idx.delete();
        got_val.delete();
        hold    = 4'hF;
        bus.req = 4'hF;
        wait_grants(5, "rr_five_grants");
        hold    = 4'h0;
        bus.req = 4'h0;
        if (got_idx.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", got_idx[i], i % NREQ);
`ifndef LFSR_RANGE_EN
            for (int i = 0; i < 5; i++)
                for (int j = i + 1; j < 5; j++) chk("rr_distinct", got_val[i] != got_val[j], 1'b1);
`endif
        end
        repeat (4) step();

        bus.req = 4'b0100;
        wait_grants(1, "single_grant");
        if (got_idx.size() > 0) chk("single_idx", got_idx[$], 2);
        repeat (4) step();

        // Pointer ends at 2; a reseed in GAP must delay, then wrap to req[0].
        bus.req = 4'b0010;
        wait_grants(1, "req1_grant");
        if (got_idx.size() > 0) chk("req1_idx", got_idx[$], 1);
        bus.req    = 4'b0011;
        bus.reseed = 1'b1;
        wait_grants(1, "after_reseed_grant");
        if (got_idx.size() > 0) chk("after_reseed_idx", got_idx[$], 0);

        found = 1'b0;
        for (int t = 0; t < WB * 2 && !found; t++) begin
            @(negedge clk);
            if (bus.gnt == 4'b0010) found = 1'b1;
        end
        chk("midgrant_seen", found, 1'b1);
        if (found) begin
            #1 rst = 1'b0;
            #1;
            chk("midgrant_gnt_drop", bus.gnt, 4'h0);
            chk("midgrant_valid_drop", bus.rnd_valid, 1'b0);
        end
        bus.req = 4'b0011;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_grants(1, "post_reset_grant");
        if (got_idx.size() > 0) chk("post_reset_idx", got_idx[$], 0);

        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 2) == 0) bus.req = bus.req | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) bus.reseed = 1'b1;
            bus.seed_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end
        bus.req = 4'h0;
        repeat (30) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_rand_arbiter.md
Name: lfsr_rand_arbiter

Overview:
- Owns the shared 8-bit LFSR random source for the game logic. Fruit spawners, bomb placement and speed pickers are the requesters.
- Sequences the LFSR's seed load and warm-up, then shares the LFSR output among NREQ requesters.
- Uses round-robin arbitration with a req/gnt handshake.
- Enforces a minimum number of LFSR steps between consecutive grants, so requesters never receive the same or adjacent-correlated value.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: LFSR/random word width.
- WARMUP, 16: LFSR free-run cycles after a seed load before the first grant (1..255).
- MIN_GAP, 2: idle cycles after each grant before the next arbitration (1..15).
- RANGE_MAX, 8'd159: upper bound on issued values. Used only with LFSR_RANGE_EN.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-low reset.
- seed_in, in, WIDTH: seed value, captured on entry to SEED.
- reseed, in, 1: single-cycle pulse requesting a new seed load.
- req, in, NREQ: level requests; held until the matching gnt.
- gnt, out, NREQ: one-hot, one-cycle grant pulse.
- rnd_out, out, WIDTH: random value; valid with rnd_valid, held between grants.
- rnd_valid, out, 1: one-cycle strobe, coincident with gnt.
- busy, out, 1: high while seeding or warming up.
- lfsr_q, in, WIDTH: current LFSR output.
- lfsr_seed, out, WIDTH: seed driven to the LFSR.
- lfsr_load, out, 1: high means the LFSR loads lfsr_seed on this edge; low means the LFSR steps every cycle.

Behaviour:
- Reset (rst low, asynchronous) values:
  - gnt=0, rnd_valid=0, rnd_out=0, lfsr_load=0, lfsr_seed=8'h01.
  - busy=1, round-robin pointer=0, gap/warm counters=0, state=INIT.
- All outputs are registered.
- FSM states: INIT, SEED, WARM, READY, GAP.
  - INIT -> SEED on the first edge after rst deasserts.
  - SEED, one cycle:
    - lfsr_seed <= seed_in, or 8'h01 when seed_in==0 (zero-lockup guard).
    - lfsr_load <= 1, then -> WARM.
  - WARM:
    - lfsr_load=0; count WARMUP cycles, then -> READY with busy<=0.
  - READY: arbitration.
    - The highest-priority asserted req is chosen, searching from the pointer upward, modulo NREQ.
    - At edge k (req sampled): gnt[i]<=1, rnd_valid<=1, rnd_out<=lfsr_q as sampled at edge k.
    - Pointer <= (i+1) mod NREQ. State -> GAP.
    - No req asserted: stay in READY, outputs idle.
  - GAP:
    - gnt and rnd_valid return to 0 after one cycle.
    - Count MIN_GAP cycles, then -> READY.
    - Back-to-back grants are therefore spaced exactly MIN_GAP+1 cycles.
- Requester handshake:
  - A requester must drop req in the cycle after its gnt.
  - A req still high when READY is re-entered is treated as a new request under round-robin order.
- reseed:
  - In READY or GAP: -> SEED on the next edge, busy<=1, no grant issued.
  - Simultaneous reseed and an eligible req in READY: reseed wins; the req stays pending.
  - In SEED or WARM: restart SEED with the current seed_in; the warm counter clears.
- The round-robin pointer is preserved across reseed and cleared only by rst.
- rst asserted mid-grant: gnt and rnd_valid drop immediately. After release, the full INIT/SEED/WARM sequence repeats.
- rnd_out retains its last granted value until the next grant. It is never updated outside READY.

Optional Feature:
- LFSR_RANGE_EN defined: rejection sampling in READY.
  - If an eligible req exists and lfsr_q > RANGE_MAX, no grant is issued; state stays READY and the pointer is unchanged. Retry on the next cycle, since the LFSR has stepped.
  - Issued values always satisfy rnd_out <= RANGE_MAX.
  - RANGE_MAX must be >= 1. A maximal-length LFSR then guarantees a grant within 255 cycles.
- LFSR_RANGE_EN undefined: RANGE_MAX is ignored; any lfsr_q is granted.

Test Plan:
- Release rst with seed_in=8'h03 -> lfsr_load high exactly 1 cycle with lfsr_seed=8'h03; busy falls 16 cycles later. Repeat with seed_in=8'h00 -> lfsr_seed=8'h01.
- Hold req=4'b1111 after warm-up -> gnt sequence 0001, 0010, 0100, 1000, 0001, each pulse 3 cycles apart. Each rnd_out equals lfsr_q at its decision edge; the 5 values are pairwise distinct.
- Single req=4'b0100 pulse held until grant -> gnt=0100 and rnd_valid on the next edge, 1 cycle wide; rnd_out holds afterwards.
- Grant req[1] only (pointer now 2), then assert reseed during GAP with req=4'b0011 pending -> no gnt through SEED+WARM (17 cycles). Then gnt=0001, since the pointer is preserved at 2 and wraps past 2 and 3 to req[0].
- Pull rst low in the same cycle gnt=0010 is high -> gnt and rnd_valid go to 0 without waiting for an edge. After release: INIT, SEED, WARM, then first grant to req[0].
- With LFSR_RANGE_EN, RANGE_MAX=15 and req=4'b0001 held -> no gnt while lfsr_q>15; the grant occurs on the first cycle with lfsr_q<=15, and rnd_out<=15.
